// File: rtl/muldiv_unit_pkg.sv
// Shared operation codes and funct encodings for the iterative multiply/divide unit.
package muldiv_unit_pkg;

   localparam int unsigned MD_DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   // R-type funct fields that decode steers to this unit.
   localparam logic [5:0] MULT_FUNCT  = 6'b011000;
   localparam logic [5:0] MULTU_FUNCT = 6'b011001;
   localparam logic [5:0] DIV_FUNCT   = 6'b011010;
   localparam logic [5:0] DIVU_FUNCT  = 6'b011011;
   localparam logic [5:0] MFHI_FUNCT  = 6'b010000;
   localparam logic [5:0] MTHI_FUNCT  = 6'b010001;
   localparam logic [5:0] MFLO_FUNCT  = 6'b010010;
   localparam logic [5:0] MTLO_FUNCT  = 6'b010011;

   function automatic logic isSigned(input md_op_e op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

   function automatic logic isDivide(input md_op_e op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; works on operand magnitudes and
// fixes signs in one final cycle, so latency is always DATA_WIDTH+1 edges.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = MD_DEFAULT_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            md_op,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   input  logic                  hi_write,
   input  logic                  lo_write,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);

   localparam int unsigned W  = DATA_WIDTH;
   localparam int unsigned CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

   state_e          state_q;
   md_op_e          op_q;
   logic [CW-1:0]   count_q;
   logic [2*W-1:0]  acc_q, acc_d, product_d;
   logic [W-1:0]    aMag_q, bMag_q, aOrig_q, hi_q, lo_q;
   logic [W-1:0]    aMag_d, bMag_d, aShift_d, bShift_d, hi_d, lo_d, quot_d, rem_d;
   logic [W:0]      trial_d;
   logic            signQuot_q, signRem_q, busy_q, done_q;
   logic            startSigned_d;

   always_comb begin
      startSigned_d = isSigned(md_op_e'(md_op));
      aMag_d = (startSigned_d && operand_a[W-1]) ? -operand_a : operand_a;
      bMag_d = (startSigned_d && operand_b[W-1]) ? -operand_b : operand_b;
   end

   // One radix-2 step: MSB-first shift-add for multiply, restoring step for divide.
   always_comb begin
      acc_d    = acc_q;
      aShift_d = aMag_q;
      bShift_d = bMag_q;
      trial_d  = '0;
      if (isDivide(op_q)) begin
         trial_d = {acc_q[2*W-1:W], aMag_q[W-1]} - {1'b0, bMag_q};
         if (!trial_d[W])
            acc_d = {trial_d[W-1:0], acc_q[W-2:0], 1'b1};
         else
            acc_d = {acc_q[2*W-2:W], aMag_q[W-1], acc_q[W-2:0], 1'b0};
         aShift_d = aMag_q << 1;
      end else begin
         acc_d    = (acc_q << 1) + (bMag_q[W-1] ? {{W{1'b0}}, aMag_q} : '0);
         bShift_d = bMag_q << 1;
      end
   end

   // Sign restoration; the -2^(W-1)/-1 case wraps back to 0x80.. through negation.
   always_comb begin
      product_d = (isSigned(op_q) && signQuot_q) ? -acc_q : acc_q;
      quot_d    = (isSigned(op_q) && signQuot_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
      rem_d     = (isSigned(op_q) && signRem_q) ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
      if (isDivide(op_q)) begin
         if (bMag_q == '0) begin
            hi_d = aOrig_q;
            lo_d = '1;
         end else begin
            hi_d = rem_d;
            lo_d = quot_d;
         end
      end else begin
         hi_d = product_d[2*W-1:W];
         lo_d = product_d[W-1:0];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         op_q       <= MD_MULT;
         count_q    <= '0;
         acc_q      <= '0;
         aMag_q     <= '0;
         bMag_q     <= '0;
         aOrig_q    <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         signQuot_q <= 1'b0;
         signRem_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (hi_write) hi_q <= operand_a;
               if (lo_write) lo_q <= operand_a;
               if (start) begin
                  state_q    <= CALC;
                  op_q       <= md_op_e'(md_op);
                  aMag_q     <= aMag_d;
                  bMag_q     <= bMag_d;
                  aOrig_q    <= operand_a;
                  signQuot_q <= operand_a[W-1] ^ operand_b[W-1];
                  signRem_q  <= operand_a[W-1];
                  acc_q      <= '0;
                  count_q    <= '0;
                  busy_q     <= 1'b1;
               end
            end
            CALC: begin
               acc_q   <= acc_d;
               aMag_q  <= aShift_d;
               bMag_q  <= bShift_d;
               count_q <= count_q + 1'b1;
               if (count_q == CW'(W - 1)) state_q <= FIX;
            end
            FIX: begin
               hi_q    <= hi_d;
               lo_q    <= lo_d;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU.
- Sits downstream of decode32 and alongside the ALU in the execute stage.
- Consumes read_data_1/read_data_2 as operands and holds the architectural HI/LO registers.
- Control stalls the PC while busy is high; MFHI/MFLO read hi/lo, and MTHI/MTLO write them directly.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width. Iteration count equals DATA_WIDTH.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  launch an operation; sampled only in IDLE.
- md_op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operand_a  input  DATA_WIDTH  rs value (multiplicand/dividend), from read_data_1.
- operand_b  input  DATA_WIDTH  rt value (multiplier/divisor), from read_data_2.
- hi_write  input  1  MTHI strobe; loads operand_a into HI.
- lo_write  input  1  MTLO strobe; loads operand_a into LO.
- busy  output  1  operation in progress; control must stall.
- done  output  1  one-cycle pulse when a new HI/LO is visible.
- hi  output  DATA_WIDTH  HI register.
- lo  output  DATA_WIDTH  LO register.

Behaviour:
- Reset (async, active-high) forces state=IDLE, hi=0, lo=0, busy=0, done=0 and counter=0. This applies immediately, including mid-operation. Any in-flight result is discarded.
- States and transitions:
  - IDLE -> CALC on start.
  - CALC -> CALC while counter<DATA_WIDTH-1.
  - CALC -> FIX at counter==DATA_WIDTH-1.
  - FIX -> IDLE.
- Start edge E0 (start=1 in IDLE):
  - latch md_op;
  - latch |a| and |b| for signed ops (raw values for unsigned ops);
  - latch sign_q = a[31]^b[31] and sign_r = a[31];
  - clear the accumulator and counter; busy=1 from E0.
- CALC, edges E1..E32, one iteration per edge:
  - Multiply: shift-add radix-2 on a 64-bit accumulator.
  - Divide: restoring radix-2; each step subtracts or keeps, and shifts in a quotient bit.
- FIX, edge E33:
  - Signed multiply: negate the 64-bit product if sign_q.
  - Signed divide: negate the quotient if sign_q, and the remainder if sign_r.
  - Write HI/LO, set busy=0 and done=1. done clears at E34.
  - Result latency is fixed at DATA_WIDTH+1 = 33 edges after the start edge, for all ops and operand values.
- Result mapping:
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- Divide by zero (operand_b==0, signed or unsigned): runs full latency; FIX writes HI=original operand_a and LO=all ones.
- Signed overflow (-2^31 / -1): LO=0x80000000 (magnitude wraps through negation), HI=0. No trap.
- start while busy: ignored. Operands and md_op are not re-sampled.
- hi_write/lo_write while busy: ignored.
- hi_write/lo_write in IDLE: the write takes effect at that edge.
- Same-edge start with hi_write/lo_write in IDLE: both accepted; the MTHI/MTLO value is visible until FIX overwrites it.
- Operand inputs are don't-care after E0; the unit holds internal copies.
- hi/lo are stable whenever busy=0 except under hi_write/lo_write. Readers must not sample them while busy=1.

Decomposition:
- includes/defines.v gains:
  - MD_MULT/MD_MULTU/MD_DIV/MD_DIVU (2-bit) codes;
  - funct codes MULT_FUNCT 6'b011000, MULTU_FUNCT 6'b011001, DIV_FUNCT 6'b011010, DIVU_FUNCT 6'b011011, MFHI_FUNCT 6'b010000, MTHI_FUNCT 6'b010001, MFLO_FUNCT 6'b010010, MTLO_FUNCT 6'b010011.
- State encodings are local.
- No sub-module. The datapath is one shared 64-bit accumulator with an adder/subtractor; splitting it adds ports without reuse.

Test Plan:
- MULT a=0xFFFFFFFE, b=0x00000003 -> at E33 HI=0xFFFFFFFF, LO=0xFFFFFFFA; done high exactly one cycle; busy high E0..E32.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU a=7, b=2 -> LO=3, HI=1.
- DIVU a=0x00001234, b=0 -> HI=0x00001234, LO=0xFFFFFFFF at E33. DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- During a MULTU 5x6: start (DIVU 9/2) and hi_write (operand_a=0xDEAD) at E5 -> both ignored; result HI=0, LO=30 at E33. A subsequent IDLE lo_write with operand_a=0xBEEF -> LO=0xBEEF next edge.
- Reset pulsed asynchronously between E10 and E11 of a DIV -> busy, done, hi and lo go 0 without a clock edge; no done pulse later. A new MULT 3x4 after reset -> LO=12 at E33.
